// File: rtl/inst_memory_sync.sv
// Byte-addressed instruction memory with a registered one-cycle fetch, a sequential
// program-load port, stall hold, selectable endianness and fetch fault reporting.
module inst_memory_sync #(
    parameter int unsigned DEPTH_BYTES = 256,
    parameter int unsigned WORD_BYTES  = 4,
    parameter bit          BIG_ENDIAN  = 1'b1,
    parameter bit          ALIGN_CHECK = 1'b1,
    parameter logic [8*WORD_BYTES-1:0] NOP_WORD = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          fetch_req,
    input  logic [31:0]                   fetch_addr,
    input  logic                          stall,
    output logic [8*WORD_BYTES-1:0]       instruction,
    output logic                          inst_valid,
    output logic                          fetch_fault,
    output logic [1:0]                    fault_code,
    input  logic                          load_start,
    input  logic                          load_valid,
    input  logic [7:0]                    load_data,
    output logic [$clog2(DEPTH_BYTES):0]  load_ptr,
    output logic                          load_full
);

    localparam int unsigned IW = 8 * WORD_BYTES;
    localparam int unsigned AW = $clog2(DEPTH_BYTES);
    localparam int unsigned PW = AW + 1;

    localparam logic [1:0] CodeNone     = 2'b00;
    localparam logic [1:0] CodeMisalign = 2'b01;
    localparam logic [1:0] CodeRange    = 2'b10;

    logic [7:0] mem_q [DEPTH_BYTES] = '{default: 8'h00};

    logic [IW-1:0] instr_d, instr_q;
    logic          valid_d, valid_q;
    logic          fault_d, fault_q;
    logic [1:0]    code_d, code_q;
    logic [PW-1:0] ptr_d, ptr_q;
    logic          full_d, full_q;

    logic          mem_we;
    logic [IW-1:0] rd_word;
    logic [32:0]   end_addr;
    logic          range_fault;
    logic          misalign_fault;

    // Reads see mem_q before this edge's write, giving read-before-write on overlap.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < int'(WORD_BYTES); i++) begin
            if (BIG_ENDIAN) begin
                rd_word[IW-8-8*i +: 8] = mem_q[fetch_addr[AW-1:0] + AW'(i)];
            end else begin
                rd_word[8*i +: 8] = mem_q[fetch_addr[AW-1:0] + AW'(i)];
            end
        end
    end

    // 33-bit sum so addresses near 2^32 cannot wrap back into range.
    always_comb begin
        end_addr       = {1'b0, fetch_addr} + 33'(WORD_BYTES);
        range_fault    = end_addr > 33'(DEPTH_BYTES);
        misalign_fault = ALIGN_CHECK && ((fetch_addr % 32'(WORD_BYTES)) != 32'd0);
    end

    always_comb begin
        instr_d = instr_q;
        valid_d = valid_q;
        fault_d = fault_q;
        code_d  = code_q;
        if (!stall) begin
            valid_d = fetch_req;
            if (fetch_req) begin
                if (range_fault) begin
                    instr_d = NOP_WORD;
                    fault_d = 1'b1;
                    code_d  = CodeRange;
                end else if (misalign_fault) begin
                    instr_d = NOP_WORD;
                    fault_d = 1'b1;
                    code_d  = CodeMisalign;
                end else begin
                    instr_d = rd_word;
                    fault_d = 1'b0;
                    code_d  = CodeNone;
                end
            end else begin
                fault_d = 1'b0;
                code_d  = CodeNone;
            end
        end
    end

    always_comb begin
        ptr_d  = ptr_q;
        full_d = full_q;
        mem_we = 1'b0;
        if (load_start) begin
            ptr_d  = '0;
            full_d = 1'b0;
        end else if (load_valid && !full_q) begin
            mem_we = 1'b1;
            ptr_d  = ptr_q + PW'(1);
            if (ptr_q + PW'(1) == PW'(DEPTH_BYTES)) begin
                full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q <= NOP_WORD;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            code_q  <= CodeNone;
            ptr_q   <= '0;
            full_q  <= 1'b0;
        end else begin
            instr_q <= instr_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            code_q  <= code_d;
            ptr_q   <= ptr_d;
            full_q  <= full_d;
        end
    end

    // Storage is not cleared by reset; only the write is suppressed during it.
    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            mem_q[ptr_q[AW-1:0]] <= load_data;
        end
    end

    assign instruction = instr_q;
    assign inst_valid  = valid_q;
    assign fetch_fault = fault_q;
    assign fault_code  = code_q;
    assign load_ptr    = ptr_q;
    assign load_full   = full_q;

endmodule

// File: doc/inst_memory_sync.md
Name: inst_memory_sync

Overview:
- Parametrised, byte-addressed instruction memory with registered (1-cycle) fetch.
- Replaces the fixed 20-byte combinational instruction store in the fetch stage.
- Adds a sequential program-load port with an auto-incrementing byte pointer, a stall-hold fetch handshake, configurable endianness, and fault reporting for misaligned or out-of-range fetches.

Parameters:
- DEPTH_BYTES, 256: number of bytes of storage; must be a multiple of WORD_BYTES.
- WORD_BYTES, 4: bytes per fetched instruction word; instruction width = 8*WORD_BYTES.
- BIG_ENDIAN, 1: 1 = byte at lowest address in MSBs (MIPS order); 0 = byte at lowest address in LSBs.
- ALIGN_CHECK, 1: 1 = fault on fetch_addr not a multiple of WORD_BYTES; 0 = unaligned fetch permitted.
- NOP_WORD, 0: word driven on instruction when a fetch faults.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- fetch_req  in  1  fetch request this cycle
- fetch_addr  in  32  byte address of word to fetch
- stall  in  1  pipeline stall; holds fetch outputs
- instruction  out  8*WORD_BYTES  registered fetched word
- inst_valid  out  1  instruction holds a fetched word
- fetch_fault  out  1  registered fault flag for the current instruction
- fault_code  out  2  00 none, 01 misaligned, 10 out of range
- load_start  in  1  restart program load at byte 0
- load_valid  in  1  load_data valid this cycle
- load_data  in  8  program byte
- load_ptr  out  $clog2(DEPTH_BYTES)+1  next byte address to be written
- load_full  out  1  memory filled; further load bytes dropped

Behaviour:
- Reset (synchronous): instruction=NOP_WORD, inst_valid=0, fetch_fault=0, fault_code=00, load_ptr=0, load_full=0.
- Reset does not clear storage. Storage contents after power-up are zero.
- Reset asserted mid-load: pointer returns to 0. Bytes already written are retained.

Fetch:
- With stall=0 at a clock edge:
  - inst_valid <= fetch_req.
  - If fetch_req=1, instruction, fetch_fault and fault_code are updated from fetch_addr.
  - If fetch_req=0, instruction holds its previous value and fetch_fault <= 0.
- With stall=1: instruction, inst_valid, fetch_fault and fault_code all hold, regardless of fetch_req or fetch_addr.
- Latency: exactly 1 clock from request to output.
- Word assembly:
  - BIG_ENDIAN=1: byte[a] in bits [8*WORD_BYTES-1 -: 8], down to byte[a+WORD_BYTES-1] in bits [7:0].
  - BIG_ENDIAN=0: byte order reversed.
- Fault checks:
  - Out of range: fetch_addr + WORD_BYTES > DEPTH_BYTES, computed without 32-bit wrap (use 33-bit compare). Gives code 10.
  - Misaligned: ALIGN_CHECK=1 and fetch_addr % WORD_BYTES != 0. Gives code 01.
  - Out of range takes priority over misaligned.
  - On any fault: instruction <= NOP_WORD, fetch_fault <= 1, inst_valid still <= 1.

Load:
- load_start=1: load_ptr <= 0, load_full <= 0. Any load_valid in the same cycle is ignored.
- load_valid=1 and load_full=0: mem[load_ptr] <= load_data, load_ptr <= load_ptr+1.
  - If load_ptr+1 == DEPTH_BYTES, load_full <= 1.
- load_valid=1 and load_full=1: byte dropped, pointer holds at DEPTH_BYTES. No wrap-around.
- Fetch and load in the same cycle to an overlapping byte: fetch returns the pre-write (old) byte (read-before-write).

Test Plan:
- Reset, then load 8C 02 00 0E 11 29 00 02 (BIG_ENDIAN=1); fetch addr 0, then addr 4 on consecutive cycles -> next cycles instruction=0x8C02000E then 0x11290002, inst_valid=1, fault_code=00; load_ptr=8.
- Same bytes with BIG_ENDIAN=0, fetch addr 0 -> instruction=0x0E00028C.
- Fetch addr 0 returns 0x8C02000E, then assert stall=1 for 3 cycles while presenting addr 4 -> instruction stays 0x8C02000E, inst_valid=1; release stall -> 0x11290002 one cycle later.
- Fetch addr 2 (ALIGN_CHECK=1) -> instruction=NOP_WORD, fetch_fault=1, fault_code=01. Fetch addr 256 (DEPTH_BYTES=256) -> fault_code=10. Fetch addr 0xFFFFFFFE -> fault_code=10 (range priority, no wrap).
- Stream 258 bytes after load_start -> load_full=1 after byte 256, load_ptr=256, bytes 257/258 not written (mem[0] unchanged). load_start -> load_ptr=0, load_full=0.
- Load midway (load_ptr=5), assert reset one cycle -> load_ptr=0, outputs at reset values, previously loaded bytes still fetchable. Fetch addr 4 while loading byte 4 same cycle -> old byte value returned.
